// File: rtl/cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmd_arbiter
// Purpose  : Two-requester round-robin arbiter for the FIR command FIFO write
//            port; keeps a write header and its data nibble together.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    input  logic             full,
    output logic             wr_en,
    output logic [3:0]       wr_data,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    localparam logic [1:0]       C_OP_WRITE = 2'b01;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_prio;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic [1:0]       w_valid;
    logic             w_winner;
    logic [1:0]       w_grant;
    logic             w_fire;
    logic [3:0]       w_sel_data;
    logic             w_complete;
    logic             w_take_owner;

    assign w_valid = {req1_valid, req0_valid};

    always_comb begin
        w_winner     = 1'b0;
        w_grant      = 2'b00;
        w_state_nxt  = r_state;
        w_complete   = 1'b0;
        w_take_owner = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_winner = r_prio;
                end else begin
                    w_winner = req1_valid;
                end
                if (|w_valid) begin
                    w_grant = {w_winner, ~w_winner};
                end
            end
            ST_HOLD: begin
                w_winner = r_owner;
                w_grant  = {r_owner, ~r_owner};
            end
            default: begin
                w_winner = 1'b0;
                w_grant  = 2'b00;
            end
        endcase

        w_fire     = (|(w_grant & w_valid)) & ~full;
        w_sel_data = w_winner ? req1_data : req0_data;

        // The data beat in HOLD is payload only and is never opcode-decoded.
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    if (w_sel_data[3:2] == C_OP_WRITE) begin
                        w_state_nxt  = ST_HOLD;
                        w_take_owner = 1'b1;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_fire) begin
                    w_state_nxt = ST_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_owner) begin
                r_owner <= w_winner;
            end
            if (w_complete) begin
                r_prio <= ~w_winner;
                if (w_winner) begin
                    r_cnt1 <= r_cnt1 + C_CNT_ONE;
                end else begin
                    r_cnt0 <= r_cnt0 + C_CNT_ONE;
                end
            end
        end
    end

    assign grant      = w_grant;
    assign req0_ready = ~full & w_grant[0];
    assign req1_ready = ~full & w_grant[1];
    assign wr_en      = w_fire;
    assign wr_data    = w_fire ? w_sel_data : 4'b0000;
    assign busy       = (r_state == ST_HOLD);
    assign pkt_cnt0   = r_cnt0;
    assign pkt_cnt1   = r_cnt1;

endmodule
`default_nettype wire
